// File: rtl/sm_fifo_pair.sv
// Paired show-ahead FIFOs (host->machine TX, machine->host RX) sharing one 2*DEPTH-entry store.
// Either side can borrow the whole store through join_tx/join_rx; a mode change flushes both sides.
module sm_fifo_pair #(
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             join_tx,
   input  logic                             join_rx,
   input  logic                             host_wr,
   input  logic [31:0]                      host_wdata,
   input  logic                             host_rd,
   output logic [31:0]                      host_rdata,
   input  logic                             pull,
   output logic [31:0]                      dout,
   input  logic                             push,
   input  logic [31:0]                      din,
   output logic                             tx_empty,
   output logic                             tx_full,
   output logic                             rx_empty,
   output logic                             rx_full,
   output logic [$clog2(2*DEPTH):0]         tx_level,
   output logic [$clog2(2*DEPTH):0]         rx_level,
   output logic [3:0]                       flags,
   input  logic [3:0]                       flags_clr
);

   localparam int PW = $clog2(2*DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      MODE_SPLIT   = 2'd0,
      MODE_JOIN_TX = 2'd1,
      MODE_JOIN_RX = 2'd2
   } mode_e;

   mode_e             mode_q, mode_d;
   logic [PW-1:0]     tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
   logic [PW-1:0]     rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
   logic [LW-1:0]     tx_level_q, tx_level_d, rx_level_q, rx_level_d;
   logic [3:0]        flags_q, flags_d;
   logic [31:0]       mem_q [2*DEPTH];
   logic [31:0]       mem_d [2*DEPTH];

   logic [LW-1:0]     tx_cap, rx_cap;
   logic [PW-1:0]     rx_base, rx_raddr, rx_waddr;
   logic              flush;
   logic              tx_wr_ok, tx_pop_ok, rx_wr_ok, rx_pop_ok;
   logic [3:0]        flag_set;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr, input logic [LW-1:0] cap);
      next_ptr = ({1'b0, ptr} == cap - LW'(1)) ? '0 : ptr + PW'(1);
   endfunction

   // Geometry follows the registered mode so stored data and pointers stay consistent until the flush.
   always_comb begin
      mode_d  = join_tx ? MODE_JOIN_TX : (join_rx ? MODE_JOIN_RX : MODE_SPLIT);
      flush   = (mode_d != mode_q);
      tx_cap  = LW'(DEPTH);
      rx_cap  = LW'(DEPTH);
      rx_base = PW'(DEPTH);
      case (mode_q)
         MODE_JOIN_TX: begin
            tx_cap = LW'(2*DEPTH);
            rx_cap = '0;
         end
         MODE_JOIN_RX: begin
            tx_cap  = '0;
            rx_cap  = LW'(2*DEPTH);
            rx_base = '0;
         end
         default: ;
      endcase
      rx_raddr = rx_base + rx_head_q;
      rx_waddr = rx_base + rx_tail_q;

      tx_empty = (tx_level_q == '0);
      tx_full  = (tx_level_q == tx_cap);
      rx_empty = (rx_level_q == '0);
      rx_full  = (rx_level_q == rx_cap);
      tx_level = tx_level_q;
      rx_level = rx_level_q;
      flags    = flags_q;
      dout       = tx_empty ? 32'h0 : mem_q[tx_head_q];
      host_rdata = rx_empty ? 32'h0 : mem_q[rx_raddr];

      // A write into a full FIFO is still accepted when a same-cycle pop frees the slot.
      tx_pop_ok = pull && !tx_empty && !flush;
      tx_wr_ok  = host_wr && (!tx_full || tx_pop_ok) && !flush;
      rx_pop_ok = host_rd && !rx_empty && !flush;
      rx_wr_ok  = push && (!rx_full || rx_pop_ok) && !flush;

      flag_set = '0;
      if (!flush) begin
         flag_set[0] = pull && tx_empty && !tx_wr_ok;
         flag_set[1] = host_wr && !tx_wr_ok;
         flag_set[2] = push && !rx_wr_ok;
         flag_set[3] = host_rd && rx_empty && !rx_wr_ok;
      end
      flags_d = (flags_q & ~flags_clr) | flag_set;

      mem_d = mem_q;
      if (tx_wr_ok) mem_d[tx_tail_q] = host_wdata;
      if (rx_wr_ok) mem_d[rx_waddr]  = din;

      tx_head_d  = tx_pop_ok ? next_ptr(tx_head_q, tx_cap) : tx_head_q;
      tx_tail_d  = tx_wr_ok  ? next_ptr(tx_tail_q, tx_cap) : tx_tail_q;
      rx_head_d  = rx_pop_ok ? next_ptr(rx_head_q, rx_cap) : rx_head_q;
      rx_tail_d  = rx_wr_ok  ? next_ptr(rx_tail_q, rx_cap) : rx_tail_q;
      tx_level_d = tx_level_q + LW'(tx_wr_ok) - LW'(tx_pop_ok);
      rx_level_d = rx_level_q + LW'(rx_wr_ok) - LW'(rx_pop_ok);

      if (flush) begin
         tx_head_d  = '0;
         tx_tail_d  = '0;
         rx_head_d  = '0;
         rx_tail_d  = '0;
         tx_level_d = '0;
         rx_level_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q     <= mode_d;
         tx_head_q  <= '0;
         tx_tail_q  <= '0;
         rx_head_q  <= '0;
         rx_tail_q  <= '0;
         tx_level_q <= '0;
         rx_level_q <= '0;
         flags_q    <= '0;
      end else begin
         mode_q     <= mode_d;
         tx_head_q  <= tx_head_d;
         tx_tail_q  <= tx_tail_d;
         rx_head_q  <= rx_head_d;
         rx_tail_q  <= rx_tail_d;
         tx_level_q <= tx_level_d;
         rx_level_q <= rx_level_d;
         flags_q    <= flags_d;
      end
   end

   // Storage is deliberately left out of reset; empty FIFOs never expose it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
